// File: rtl/core_dmem_responder_pkg.sv
// Shared widths, stall-LFSR definition and response-register layout for the dmem responder.
// Pure declarations, no logic of its own.
// Not applicable: nothing here carries traffic.
package core_dmem_responder_pkg;

    // Core data-memory bus widths (upper bit indices).
    localparam int MEM_ADDR_R = 63;
    localparam int MEM_DATA_R = 63;
    localparam int MEM_STRB_R = 7;

    // Wait counter covers WAIT_CYCLES 0..15.
    localparam int WAIT_W = 4;

    // Stall LFSR: x^16 + x^14 + x^13 + x^11, shifted left, feedback into bit 0.
    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // Registered response state; rd_sel marks that the last grant was a read hit.
    typedef struct packed {
        logic err;
        logic rd_sel;
    } rsp_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/core_dmem_responder_if.sv
// Core data-memory req/gnt bus between the core (master) and the memory responder (slave).
// Wires only, no latency.
// Master holds req and payload stable until the slave returns gnt.
interface core_dmem_responder_if;
    import core_dmem_responder_pkg::*;

    logic                  dmem_req;
    logic [MEM_ADDR_R:0]   dmem_addr;
    logic                  dmem_wen;
    logic [MEM_STRB_R:0]   dmem_strb;
    logic [MEM_DATA_R:0]   dmem_wdata;
    logic                  dmem_gnt;
    logic                  dmem_err;
    logic [MEM_DATA_R:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
        input  dmem_gnt, dmem_err, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
        output dmem_gnt, dmem_err, dmem_rdata
    );

endinterface

// File: rtl/core_dmem_ram.sv
// Single-port synchronous doubleword array with byte write strobes.
// Read data registered one cycle after ren; write commits on the clock edge with wen.
// No backpressure: the caller never raises ren and wen together.
module core_dmem_ram #(
    parameter int WORDS = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic             ren,
    input  logic             wen,
    input  logic [7:0]       strb,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem_q [WORDS];
    logic [63:0] rdata_q;

    // Array contents are deliberately unreset; only strobed bytes are written, read data is held until the next read.
    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < 8; i++) begin
                if (strb[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (ren) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/core_dmem_responder.sv
// SRAM-backed data-memory responder for the core req/gnt bus.
// Grant after WAIT_CYCLES held-req cycles (plus optional LFSR stalls); response one cycle after grant.
// Backpressure by withholding gnt; response registers hold until the next grant.
module core_dmem_responder
    import core_dmem_responder_pkg::*;
#(
    parameter logic [63:0]       MEM_BASE    = 64'h0000_0000_0001_0000,
    parameter int                MEM_WORDS   = 1024,
    parameter int                WAIT_CYCLES = 0,
    parameter bit                STALL_EN    = 1'b0,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    core_dmem_responder_if.slave dmem
);

    localparam int                IDX_W     = $clog2(MEM_WORDS);
    localparam logic [WAIT_W-1:0] WAIT_RLD  = WAIT_W'(WAIT_CYCLES);
    localparam logic [63:0]       MEM_BYTES = 64'(MEM_WORDS) * 64'd8;

    logic [WAIT_W-1:0] wait_ctr_q, wait_ctr_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    rsp_t              rsp_q, rsp_d;

    logic              gnt;
    logic              stall;
    logic              hit;
    logic [63:0]       offset;
    logic [IDX_W-1:0]  index;
    logic [63:0]       ram_rdata;

    // Range check via the offset avoids overflow of MEM_BASE + size near the top of the address space.
    assign offset = dmem.dmem_addr - MEM_BASE;
    assign hit    = (dmem.dmem_addr >= MEM_BASE) && (offset < MEM_BYTES);
    assign index  = offset[IDX_W+2:3];
    assign stall  = STALL_EN && lfsr_q[0];

    // Gated by reset so gnt drops the instant reset asserts and no write can commit during reset.
    assign gnt = g_resetn && dmem.dmem_req && (wait_ctr_q == '0) && !stall;

    // Wait counter counts down while a request is held; reloads on grant or when the request goes away.
    always_comb begin
        wait_ctr_d = wait_ctr_q;
        if (gnt || !dmem.dmem_req) begin
            wait_ctr_d = WAIT_RLD;
        end else if (wait_ctr_q != '0) begin
            wait_ctr_d = wait_ctr_q - WAIT_W'(1);
        end
    end

    // Stall LFSR free-runs every cycle when stalls are enabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (STALL_EN) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // Response state only changes on a grant: miss flags error, read hit selects RAM data, write hit returns zero.
    always_comb begin
        rsp_d = rsp_q;
        if (gnt) begin
            rsp_d.err    = !hit;
            rsp_d.rd_sel = hit && !dmem.dmem_wen;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wait_ctr_q <= WAIT_RLD;
            lfsr_q     <= LFSR_SEED;
            rsp_q      <= '0;
        end else begin
            wait_ctr_q <= wait_ctr_d;
            lfsr_q     <= lfsr_d;
            rsp_q      <= rsp_d;
        end
    end

    core_dmem_ram #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (g_clk),
        .addr  (index),
        .ren   (gnt && hit && !dmem.dmem_wen),
        .wen   (gnt && hit && dmem.dmem_wen),
        .strb  (dmem.dmem_strb),
        .wdata (dmem.dmem_wdata),
        .rdata (ram_rdata)
    );

    // RAM output register only loads on read grants, so masking with rd_sel gives a held, reset-to-zero response.
    assign dmem.dmem_gnt   = gnt;
    assign dmem.dmem_err   = rsp_q.err;
    assign dmem.dmem_rdata = rsp_q.rd_sel ? ram_rdata : 64'd0;

endmodule
